// File: rtl/iob_ram_2p_streamer_pkg.sv
// Shared types and sizing for the two-port RAM read streamer.
package iob_ram_2p_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned BUF_DEPTH = 3;
  localparam int unsigned OCC_W     = 2;
  localparam int unsigned PTR_W     = 2;
  // Wide enough to hold occupancy plus the inflight flag without overflow.
  localparam int unsigned CREDIT_W  = 3;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/iob_ram_2p_streamer_buf.sv
// Three-entry in-order register FIFO holding captured RAM words until the stream takes them.
module iob_ram_2p_streamer_buf
  import iob_ram_2p_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [OCC_W-1:0]  occ_q;
  logic              do_push, do_pop;

  assign do_pop  = pop && (occ_q != '0);
  // A full buffer may still accept a word when the head leaves in the same cycle.
  assign do_push = push && ((occ_q < OCC_W'(BUF_DEPTH)) || do_pop);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop) occ_q <= occ_q + OCC_W'(1);
      else if (!do_push && do_pop) occ_q <= occ_q - OCC_W'(1);
    end
  end

  assign occ        = occ_q;
  assign head_data  = mem_q[rd_q];
  assign head_valid = (occ_q != '0);

endmodule

// File: rtl/iob_ram_2p_streamer.sv
// Walks an address window through a RAM read port and emits the words as a valid/ready stream.
module iob_ram_2p_streamer
  import iob_ram_2p_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              r_en_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [DATA_W-1:0] r_data_i,
  input  logic              r_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              inflight_q, inflight_d;

  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] head_data;
  logic              head_valid;
  logic              credit_ok, accept, push, pop;

  iob_ram_2p_streamer_buf #(.DATA_W(DATA_W)) u_buf (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .push       (push),
    .pop        (pop),
    .wdata      (r_data_i),
    .occ        (occ),
    .head_data  (head_data),
    .head_valid (head_valid)
  );

  // Only registered state feeds the read request, so neither ready reaches r_en_o.
  assign credit_ok = (CREDIT_W'(occ) + CREDIT_W'(inflight_q)) < CREDIT_W'(BUF_DEPTH);
  assign r_en_o    = cke_i && (state_q == ST_RUN) && (issue_q != '0) && credit_ok;
  assign r_addr_o  = addr_q;
  assign accept    = r_en_o && r_ready_i;
  assign push      = cke_i && inflight_q;
  assign pop       = cke_i && head_valid && ready_i;

  assign data_o  = head_data;
  assign valid_o = head_valid;
  assign last_o  = head_valid && (beat_q == CNT_W'(1));
  assign busy_o  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o  = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    beat_d     = beat_q;
    inflight_d = accept;
    if (pop) beat_d = beat_q - CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d = ST_RUN;
            addr_d  = addr_i;
            issue_d = len_i;
            beat_d  = len_i;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          addr_d  = addr_q + ADDR_W'(1);
          issue_d = issue_q - CNT_W'(1);
          if (issue_q == CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat_d == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_iob_ram_2p_streamer.sv
// Bench for iob_ram_2p_streamer: RAM model, stream scoreboard and per-window timing checks.
module tb_iob_ram_2p_streamer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int BUDGET = 4000;

  logic              clk = 1'b0;
  logic              cke_i = 1'b1;
  logic              arst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [ADDR_W:0]   len_i = '0;
  logic              busy_o, done_o, r_en_o, valid_o, last_o;
  logic [ADDR_W-1:0] r_addr_o;
  logic [DATA_W-1:0] r_data_i = '0;
  logic              r_ready_i = 1'b1;
  logic [DATA_W-1:0] data_o;
  logic              ready_i = 1'b1;

  iob_ram_2p_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i     (clk),
    .cke_i     (cke_i),
    .arst_i    (arst_i),
    .start_i   (start_i),
    .addr_i    (addr_i),
    .len_i     (len_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .r_en_o    (r_en_o),
    .r_addr_o  (r_addr_o),
    .r_data_i  (r_data_i),
    .r_ready_i (r_ready_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .last_o    (last_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // RAM model: data only meaningful the cycle after an accepted read, garbage otherwise.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (r_en_o && r_ready_i) r_data_i <= mem[r_addr_o];
    else r_data_i <= $urandom;
  end

  // Reference: expected beats of the current window and expected read addresses.
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] exp_raddr;
  int                issue_left = 0;
  int                beats_seen = 0;

  int                outstanding = 0;
  logic              prev_stall = 1'b0, prev_last = 1'b0, prev_rstall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_raddr;
  logic [DATA_W-1:0] want;
  logic              acc, xf;

  always @(negedge clk) begin
    if (arst_i) begin
      outstanding = 0;
      prev_stall  = 1'b0;
      prev_rstall = 1'b0;
    end else begin
      acc = r_en_o && r_ready_i;
      xf  = valid_o && ready_i;
      if (prev_stall) begin
        check("stall_valid_hold", valid_o, 1);
        check("stall_data_hold", data_o, prev_data);
        check("stall_last_hold", last_o, prev_last);
      end
      if (prev_rstall) begin
        check("rstall_en_hold", r_en_o, 1);
        check("rstall_addr_hold", r_addr_o, prev_raddr);
      end
      if (acc) begin
        if (issue_left == 0) check("extra_read", 1, 0);
        else begin
          check("read_addr", r_addr_o, exp_raddr);
          exp_raddr++;
          issue_left--;
        end
      end
      if (xf) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          want = exp_q.pop_front();
          check("beat_data", data_o, want);
          check("beat_last", last_o, exp_q.size() == 0);
          beats_seen++;
        end
      end
      outstanding = outstanding + int'(acc) - int'(xf);
      if (acc) check("occupancy_le3", outstanding > 3, 0);
      prev_stall  = valid_o && !ready_i;
      prev_data   = data_o;
      prev_last   = last_o;
      prev_rstall = r_en_o && !r_ready_i;
      prev_raddr  = r_addr_o;
    end
  end

  function automatic logic ready_pat(input int mode, input int k);
    if (mode == 1) return (k >= 8 && k <= 12) ? 1'b0 : 1'(k & 1);
    if (mode == 2) return $urandom_range(0, 2) != 0;
    return 1'b1;
  endfunction

  function automatic logic rready_pat(input int mode, input int k);
    if (mode == 1) return !(k >= 1 && k <= 4);
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  task automatic load_window(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
    logic [ADDR_W-1:0] idx;
    for (int i = 0; i < int'(n); i++) begin
      idx = a + ADDR_W'(i);
      exp_q.push_back(mem[idx]);
    end
    exp_raddr  = a;
    issue_left = int'(n);
    beats_seen = 0;
  endtask

  task automatic run_window(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n,
                            input int rmode, input int rrmode, input int exp_done);
    int done_k;
    load_window(a, n);
    @(posedge clk); #1;
    start_i = 1'b1; addr_i = a; len_i = n; ready_i = 1'b1; r_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; addr_i = ADDR_W'($urandom); len_i = (ADDR_W+1)'($urandom);
    done_k = 0;
    for (int k = 1; k < BUDGET && done_k == 0; k++) begin
      ready_i   = ready_pat(rmode, k);
      r_ready_i = rready_pat(rrmode, k);
      if (k == 1 && n != 0) begin
        check("busy_cycle1", busy_o, 1);
        check("r_en_cycle1", r_en_o, 1);
      end
      if (n == 0) begin
        check("zero_len_no_read", r_en_o, 0);
        check("zero_len_no_valid", valid_o, 0);
      end
      if (done_o) done_k = k;
      else begin
        @(posedge clk); #1;
      end
    end
    if (done_k == 0) check("done_timeout", 0, 1);
    else begin
      check("done_after_all_beats", exp_q.size(), 0);
      check("done_beat_count", beats_seen, n);
      check("busy_low_at_done", busy_o, 0);
      if (exp_done != 0) check("done_cycle", done_k, exp_done);
      @(posedge clk); #1;
      check("done_one_cycle", done_o, 0);
    end
    ready_i = 1'b1; r_ready_i = 1'b1;
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    int                rmode;
    int                rrmode;
    int                exp_done;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{addr: 10'h000, len: 11'd1024, rmode: 0, rrmode: 0, exp_done: 1027};
    vecs[1] = '{addr: 10'h3FE, len: 11'd4,    rmode: 0, rrmode: 0, exp_done: 7};
    vecs[2] = '{addr: 10'h000, len: 11'd0,    rmode: 0, rrmode: 0, exp_done: 1};
    vecs[3] = '{addr: 10'h000, len: 11'd8,    rmode: 1, rrmode: 0, exp_done: 0};
    vecs[4] = '{addr: 10'h000, len: 11'd4,    rmode: 0, rrmode: 1, exp_done: 11};

    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i + 32);

    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_r_en", r_en_o, 0);
    check("rst_r_addr", r_addr_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_last", last_o, 0);
    repeat (2) @(posedge clk);
    #1 arst_i = 1'b0;

    for (int v = 0; v < 5; v++)
      run_window(vecs[v].addr, vecs[v].len, vecs[v].rmode, vecs[v].rrmode, vecs[v].exp_done);

    // Start while busy is ignored: a second start mid-window must not change the stream.
    begin
      int done_k;
      load_window(10'd100, 11'd6);
      @(posedge clk); #1;
      start_i = 1'b1; addr_i = 10'd100; len_i = 11'd6;
      @(posedge clk); #1;
      addr_i = 10'd500; len_i = 11'd9;
      @(posedge clk); #1;
      start_i = 1'b0;
      done_k = 0;
      for (int k = 2; k < BUDGET && done_k == 0; k++) begin
        if (done_o) done_k = k;
        else begin
          @(posedge clk); #1;
        end
      end
      check("busy_start_done", done_k, 9);
      check("busy_start_beats", beats_seen, 6);
      @(posedge clk); #1;
    end

    // Reset in the middle of a window aborts with no done pulse.
    begin
      int guard;
      load_window(10'd0, 11'd16);
      @(posedge clk); #1;
      start_i = 1'b1; addr_i = '0; len_i = 11'd16;
      @(posedge clk); #1;
      start_i = 1'b0;
      guard = 0;
      while (beats_seen < 3 && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      check("reset_reach_beat3", beats_seen, 3);
      arst_i = 1'b1;
      #1;
      check("abort_busy", busy_o, 0);
      check("abort_done", done_o, 0);
      check("abort_r_en", r_en_o, 0);
      check("abort_r_addr", r_addr_o, 0);
      check("abort_valid", valid_o, 0);
      check("abort_data", data_o, 0);
      check("abort_last", last_o, 0);
      exp_q.delete();
      issue_left = 0;
      repeat (2) @(posedge clk);
      #1 arst_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
        check("abort_no_done", done_o, 0);
        check("abort_no_valid", valid_o, 0);
        @(posedge clk); #1;
      end
      run_window(10'd5, 11'd2, 0, 0, 5);
    end

    // Randomised windows over random RAM contents with random stalls on both sides.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int w = 0; w < 8; w++)
      run_window(ADDR_W'($urandom), (ADDR_W+1)'($urandom_range(1, 48)), 2, 2, 0);
    run_window(10'h3F0, 11'd40, 2, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_ram_2p_streamer.md
# iob_ram_2p_streamer

Read-side engine for a two-port RAM: on a start pulse, walks a contiguous address window through the RAM read port (`r_en`/`r_addr`/`r_data`/`r_ready`) and emits the words in order as a valid/ready stream, with `last_o` on the final word. It sits between an `iob_ram_2p` instance and a stream consumer. An independent producer fills the same RAM through the write port.

## Interface
- `DATA_W`, 32, RAM word and stream data width
- `ADDR_W`, 10, RAM address width; window length counts up to 2^ADDR_W words
- `clk_i` in 1: clock
- `cke_i` in 1: clock enable; when low, all state holds and no new RAM read is issued
- `arst_i` in 1: reset, asynchronous, active-high
- `start_i` in 1: start pulse; sampled only in IDLE
- `addr_i` in ADDR_W: first RAM address, sampled with `start_i`
- `len_i` in ADDR_W+1: word count, sampled with `start_i`; range 0..2^ADDR_W
- `busy_o` out 1: high from the cycle after an accepted start until `done_o`
- `done_o` out 1: one-cycle pulse after the last word is accepted
- `r_en_o` out 1: RAM read request
- `r_addr_o` out ADDR_W: RAM read address
- `r_data_i` in DATA_W: RAM read data, valid one cycle after an accepted request
- `r_ready_i` in 1: RAM read-port ready; a request is accepted when `r_en_o && r_ready_i`
- `data_o` out DATA_W: stream data
- `valid_o` out 1: stream valid
- `ready_i` in 1: stream ready; a beat transfers when `valid_o && ready_i`
- `last_o` out 1: marks the final beat of the window

## Operation
- **FSM states**
  - IDLE: accepts `start_i`.
  - RUN: issues reads.
  - DRAIN: all reads are issued; waits for the buffer to empty.
  - DONE: one cycle; drives `done_o`, then returns to IDLE.
- **IDLE → RUN**: on `start_i` with `len_i != 0`. This latches `addr_i` into the address register and `len_i` into both the issue counter and the beat counter.
- **Zero length**: `start_i` with `len_i == 0` goes IDLE → DONE directly. No RAM read is issued and no beat is emitted.
- **Read issue (RUN)**: `r_en_o = (issue count > 0) && (occupancy + inflight < 3)`.
  - On acceptance, the address increments modulo 2^ADDR_W and the issue count decrements.
  - The address wraps: 0x3FF+1 → 0x000.
- **Capture**: `r_data_i` is written into the 3-entry in-order buffer exactly in the cycle after an accepted request. The 1-bit `inflight` flag tracks that cycle. `r_data_i` is ignored in all other cycles.
- **RUN → DRAIN**: when the issue count reaches 0.
- **DRAIN → DONE**: when the beat counter reaches 0, i.e. the last beat has transferred.
- **Stream output**:
  - `data_o`/`valid_o` come from the buffer head.
  - `last_o = valid_o && (beat count == 1)`.
  - Each transfer decrements the beat count.
- **No combinational paths**: there is no combinational path from `ready_i` or `r_ready_i` to `r_en_o`.
- **Busy start**: `start_i` while busy is ignored.
- **Stream stability**: while `valid_o && !ready_i`, `data_o` and `last_o` hold stable.

## Timing
- **Reset values**: every output is 0. The FSM is IDLE, the buffer is empty, `inflight` is 0 and the counters are 0.
- **Reset mid-operation**: aborts immediately. No `done_o` is produced and buffered data is discarded.
- **Start latency**:
  - `start_i` is sampled at edge 0.
  - `busy_o` and the first `r_en_o` are high in cycle 1.
  - Data is captured at edge 2.
  - `valid_o` is high in cycle 3.
- **Throughput**: one beat per cycle when `ready_i` and `r_ready_i` are held high. A window of N words ends with `done_o` in cycle N+3.
- **`done_o` timing**: high the cycle after the last transfer. `busy_o` drops in that same cycle.
- **Stall on `r_ready_i`**: `r_ready_i` low holds `r_addr_o` and `r_en_o`; nothing is skipped or duplicated.
- **Stall on `ready_i`**: `ready_i` low stops issue once occupancy + inflight reaches 3. No overflow occurs.
- **Simultaneous push and pop**: on a full buffer in the same cycle, occupancy is unchanged.
- **Clock enable**: `cke_i` low freezes all registers. `r_en_o` is forced low while `cke_i` is low.

## Structure
- **Package `iob_ram_2p_streamer_pkg`** holds:
  - state encodings IDLE=0, RUN=1, DRAIN=2, DONE=3;
  - `BUF_DEPTH=3`;
  - the occupancy width.
- **Sub-module `iob_ram_2p_streamer_buf`**: 3-entry register FIFO with push, pop, occupancy, head data and head valid.
- **Top module**: holds the FSM, address and counters, and the credit logic.

## Test plan
- **Full sweep**: pre-fill all 1024 words of an `iob_ram_2p` with addr+32, `ready_i`=1, start addr=0, len=1024.
  - 1024 beats with values 32..1055 in order.
  - `last_o` only on 1055.
  - `done_o` in cycle 1027.
- **Wrap**: addr=0x3FE, len=4.
  - Reads at 0x3FE, 0x3FF, 0x000, 0x001.
  - Beats 1054, 1055, 32, 33.
- **Zero length**: len=0.
  - `done_o` in cycle 1.
  - `r_en_o` and `valid_o` never high.
- **Backpressure**: len=8 with `ready_i` toggled 1010… plus 5 cycles low mid-stream.
  - All 8 beats arrive exactly once, in order.
  - `data_o` is stable while stalled.
  - occupancy never exceeds 3.
- **RAM not ready**: `r_ready_i` low for 4 cycles after the first request.
  - `r_addr_o` holds 0 during the stall.
  - No capture happens during the stall.
  - Output sequence is unchanged.
- **Reset mid-operation**: assert `arst_i` at beat 3 of len=16.
  - All outputs 0 immediately.
  - No `done_o`.
  - A fresh start, addr=5 len=2, yields 37, 38.
